battle_engine: RTL and testbench

//  Parametrised turn-based battle controller with datapath for one player and one AI combatant.

---
 rtl/battle_pkg.sv | 34 +++
 rtl/battle_damage_unit.sv | 43 ++++
 rtl/battle_engine.sv | 156 +++++++++++++++
 tb/tb_battle_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared constants and arithmetic helpers for the battle engine.
// The helpers work on a fixed 32-bit internal width. Callers resize the
// result to their own widths, which are expected to be at most 32 bits.
package battle_pkg;

    localparam int unsigned CALC_W = 32;

    localparam logic [2:0] S_LOAD    = 3'd0;
    localparam logic [2:0] S_CALC1   = 3'd1;
    localparam logic [2:0] S_APPLY1  = 3'd2;
    localparam logic [2:0] S_CALC2   = 3'd3;
    localparam logic [2:0] S_APPLY2  = 3'd4;
    localparam logic [2:0] S_VICTORY = 3'd5;
    localparam logic [2:0] S_LOSS    = 3'd6;

    // Saturating subtract: HP bottoms out at zero and never wraps.
    function automatic logic [CALC_W-1:0] sat_sub(input logic [CALC_W-1:0] hp,
                                                  input logic [CALC_W-1:0] dmg);
        return (hp > dmg) ? (hp - dmg) : '0;
    endfunction

    // Clamp a raw damage product to the largest value an hp_w-bit register can hold.
    function automatic logic [CALC_W-1:0] clamp_dmg(input logic [CALC_W-1:0] product,
                                                    input int unsigned       hp_w);
        logic [CALC_W-1:0] max_v;
        if (hp_w >= CALC_W) begin
            max_v = '1;
        end else begin
            max_v = (CALC_W'(1) << hp_w) - CALC_W'(1);
        end
        return (product > max_v) ? max_v : product;
    endfunction

endpackage

// File: rtl/battle_damage_unit.sv
// Damage datapath shared by both attackers.
// It registers the clamped power*multiplier product during a CALC state.
// It also provides the saturated defender HP that results from applying that damage.
module battle_damage_unit
    import battle_pkg::*;
#(
    parameter int unsigned HP_W  = 8,
    parameter int unsigned PWR_W = 4,
    parameter int unsigned MUL_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             calc_en,
    input  logic             clear,
    input  logic [PWR_W-1:0] pwr,
    input  logic [MUL_W-1:0] mul,
    input  logic [HP_W-1:0]  hp_in,
    output logic [HP_W-1:0]  dmg,
    output logic [HP_W-1:0]  hp_out
);

    localparam int unsigned PROD_W = PWR_W + MUL_W;

    logic [PROD_W-1:0] product;

    // Both operands are widened to the full product width, so the product is never truncated.
    assign product = {{MUL_W{1'b0}}, pwr} * {{PWR_W{1'b0}}, mul};

    // Register the clamped damage for the attack being resolved.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dmg <= '0;
        end else if (clear) begin
            dmg <= '0;
        end else if (calc_en) begin
            dmg <= HP_W'(clamp_dmg(CALC_W'(product), HP_W));
        end
    end

    // Defender HP after the registered damage is applied.
    assign hp_out = HP_W'(sat_sub(CALC_W'(hp_in), CALC_W'(dmg)));

endmodule

// File: rtl/battle_engine.sv
// Turn-based battle controller for one player and one AI combatant.
// It latches both moves on a go edge and resolves the first attacker.
// If that attack does not end the battle, it then resolves the second attacker.
//
// Control inputs:
//  go       - level input; only its rising edge (seen in S_LOAD) starts a round.
//             Edges that arrive in any other state are dropped, not queued.
//  new_game - single-cycle pulse; it overrides everything and restarts on the next edge.
module battle_engine
    import battle_pkg::*;
#(
    parameter int unsigned HP_W    = 8,
    parameter int unsigned PWR_W   = 4,
    parameter int unsigned MUL_W   = 2,
    parameter int unsigned HP_INIT = 100
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic             new_game,
    input  logic [PWR_W-1:0] p_pwr,
    input  logic [MUL_W-1:0] p_mul,
    input  logic [PWR_W-1:0] a_pwr,
    input  logic [MUL_W-1:0] a_mul,
    input  logic             p_first,
    output logic [HP_W-1:0]  p_hp,
    output logic [HP_W-1:0]  a_hp,
    output logic [HP_W-1:0]  last_dmg,
    output logic [2:0]       state_o,
    output logic             busy,
    output logic             victory,
    output logic             loss
);

    localparam logic [HP_W-1:0] HP_START = HP_W'(HP_INIT);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             go_q;
    logic             go_rise;

    logic [PWR_W-1:0] mv_p_pwr;
    logic [MUL_W-1:0] mv_p_mul;
    logic [PWR_W-1:0] mv_a_pwr;
    logic [MUL_W-1:0] mv_a_mul;
    logic             mv_p_first;

    logic             first_half;
    logic             atk_is_p;
    logic             calc_en;
    logic             apply_en;
    logic [PWR_W-1:0] atk_pwr;
    logic [MUL_W-1:0] atk_mul;
    logic [HP_W-1:0]  def_hp;
    logic [HP_W-1:0]  dmg;
    logic [HP_W-1:0]  def_hp_new;

    assign go_rise = go & ~go_q;

    // Track the previous go level for edge detection; this runs in every state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            go_q <= 1'b0;
        end else begin
            go_q <= go;
        end
    end

    // The first half of the round belongs to the latched first attacker.
    // The second half belongs to the other combatant.
    assign first_half = (state == S_CALC1) || (state == S_APPLY1);
    assign atk_is_p   = first_half ? mv_p_first : ~mv_p_first;
    assign calc_en    = (state == S_CALC1) || (state == S_CALC2);
    assign apply_en   = (state == S_APPLY1) || (state == S_APPLY2);
    assign atk_pwr    = atk_is_p ? mv_p_pwr : mv_a_pwr;
    assign atk_mul    = atk_is_p ? mv_p_mul : mv_a_mul;
    assign def_hp     = atk_is_p ? a_hp : p_hp;

    battle_damage_unit #(
        .HP_W  (HP_W),
        .PWR_W (PWR_W),
        .MUL_W (MUL_W)
    ) u_dmg (
        .clk     (clk),
        .resetn  (resetn),
        .calc_en (calc_en),
        .clear   (new_game),
        .pwr     (atk_pwr),
        .mul     (atk_mul),
        .hp_in   (def_hp),
        .dmg     (dmg),
        .hp_out  (def_hp_new)
    );

    // Round sequencing. A KO in either APPLY state ends the battle immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (go_rise) state_nxt = S_CALC1;
            S_CALC1:   state_nxt = S_APPLY1;
            S_APPLY1:  if (def_hp_new == '0) state_nxt = atk_is_p ? S_VICTORY : S_LOSS;
                       else                  state_nxt = S_CALC2;
            S_CALC2:   state_nxt = S_APPLY2;
            S_APPLY2:  if (def_hp_new == '0) state_nxt = atk_is_p ? S_VICTORY : S_LOSS;
                       else                  state_nxt = S_LOAD;
            S_VICTORY: state_nxt = S_VICTORY;
            S_LOSS:    state_nxt = S_LOSS;
            default:   state_nxt = S_LOAD;
        endcase
    end

    // State and HP registers. new_game overrides any transition or update in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_LOAD;
            p_hp     <= HP_START;
            a_hp     <= HP_START;
            last_dmg <= '0;
        end else if (new_game) begin
            state    <= S_LOAD;
            p_hp     <= HP_START;
            a_hp     <= HP_START;
            last_dmg <= '0;
        end else begin
            state <= state_nxt;
            if (apply_en) begin
                last_dmg <= dmg;
                if (atk_is_p) a_hp <= def_hp_new;
                else          p_hp <= def_hp_new;
            end
        end
    end

    // Move latch. Once a round has started, the inputs may change freely.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mv_p_pwr   <= '0;
            mv_p_mul   <= '0;
            mv_a_pwr   <= '0;
            mv_a_mul   <= '0;
            mv_p_first <= 1'b0;
        end else if (!new_game && (state == S_LOAD) && go_rise) begin
            mv_p_pwr   <= p_pwr;
            mv_p_mul   <= p_mul;
            mv_a_pwr   <= a_pwr;
            mv_a_mul   <= a_mul;
            mv_p_first <= p_first;
        end
    end

    assign state_o = state;
    assign busy    = calc_en || apply_en;
    assign victory = (state == S_VICTORY);
    assign loss    = (state == S_LOSS);

endmodule

// File: tb/tb_battle_engine.sv
// Self-checking bench for battle_engine with a round-level reference model.
module tb_battle_engine;

    localparam int HP_INIT = 100;
    localparam int HP_MAX  = 255;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] p_pwr = '0;
    logic [1:0] p_mul = '0;
    logic [3:0] a_pwr = '0;
    logic [1:0] a_mul = '0;
    logic       p_first = 1'b0;
    logic [7:0] p_hp;
    logic [7:0] a_hp;
    logic [7:0] last_dmg;
    logic [2:0] state_o;
    logic       busy;
    logic       victory;
    logic       loss;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: whole-battle view
    int m_php  = HP_INIT;
    int m_ahp  = HP_INIT;
    int m_last = 0;
    int m_over = 0;   // 0 = ongoing, 1 = player won, 2 = player lost

    battle_engine #(
        .HP_W    (8),
        .PWR_W   (4),
        .MUL_W   (2),
        .HP_INIT (HP_INIT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .go       (go),
        .new_game (new_game),
        .p_pwr    (p_pwr),
        .p_mul    (p_mul),
        .a_pwr    (a_pwr),
        .a_mul    (a_mul),
        .p_first  (p_first),
        .p_hp     (p_hp),
        .a_hp     (a_hp),
        .last_dmg (last_dmg),
        .state_o  (state_o),
        .busy     (busy),
        .victory  (victory),
        .loss     (loss)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    endtask

    function automatic int dmg_of(input int pwr, input int mul);
        int d;
        d = pwr * mul;
        return (d > HP_MAX) ? HP_MAX : d;
    endfunction

    function automatic int hp_after(input int hp, input int d);
        return (hp > d) ? hp - d : 0;
    endfunction

    task automatic model_reset();
        m_php  = HP_INIT;
        m_ahp  = HP_INIT;
        m_last = 0;
        m_over = 0;
    endtask

    task automatic model_round(input int pp, input int pm, input int ap, input int am, input int pf);
        int dp, da;
        dp = dmg_of(pp, pm);
        da = dmg_of(ap, am);
        if (pf != 0) begin
            m_ahp = hp_after(m_ahp, dp); m_last = dp;
            if (m_ahp == 0) m_over = 1;
            else begin
                m_php = hp_after(m_php, da); m_last = da;
                if (m_php == 0) m_over = 2;
            end
        end else begin
            m_php = hp_after(m_php, da); m_last = da;
            if (m_php == 0) m_over = 2;
            else begin
                m_ahp = hp_after(m_ahp, dp); m_last = dp;
                if (m_ahp == 0) m_over = 1;
            end
        end
    endtask

    task automatic check_against_model(input string tag);
        int exp_state;
        exp_state = (m_over == 1) ? 5 : (m_over == 2) ? 6 : 0;
        check_eq({tag, ".state"},    int'(state_o),  exp_state);
        check_eq({tag, ".p_hp"},     int'(p_hp),     m_php);
        check_eq({tag, ".a_hp"},     int'(a_hp),     m_ahp);
        check_eq({tag, ".last_dmg"}, int'(last_dmg), m_last);
        check_eq({tag, ".victory"},  int'(victory),  (m_over == 1) ? 1 : 0);
        check_eq({tag, ".loss"},     int'(loss),     (m_over == 2) ? 1 : 0);
        check_eq({tag, ".busy"},     int'(busy),     0);
    endtask

    // driver: one go pulse, scramble the inputs, then wait for the round to settle
    task automatic play_round(input string tag, input int pp, input int pm,
                              input int ap, input int am, input int pf);
        logic settled;
        @(negedge clk);
        p_pwr = 4'(pp); p_mul = 2'(pm); a_pwr = 4'(ap); a_mul = 2'(am); p_first = 1'(pf);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        p_pwr = 4'($urandom_range(0, 15)); p_mul = 2'($urandom_range(0, 3));
        a_pwr = 4'($urandom_range(0, 15)); a_mul = 2'($urandom_range(0, 3));
        p_first = 1'($urandom_range(0, 1));
        check_eq({tag, ".busy_in_round"}, int'(busy), 1);
        settled = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (state_o == 3'd0 || state_o == 3'd5 || state_o == 3'd6) begin
                settled = 1'b1;
                break;
            end
        end
        check_eq({tag, ".settled"}, int'(settled), 1);
        model_round(pp, pm, ap, am, pf);
        check_against_model(tag);
    endtask

    task automatic do_new_game(input string tag);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        check_against_model(tag);
    endtask

    initial begin
        int cnt;

        // reset
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_against_model("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_against_model("reset_release");

        // player attacks first
        play_round("p_first", 5, 2, 3, 1, 1);
        check_eq("p_first.a_hp_const", int'(a_hp), 90);
        check_eq("p_first.p_hp_const", int'(p_hp), 97);
        check_eq("p_first.dmg_const",  int'(last_dmg), 3);

        // KO by the first attacker; the AI never strikes back
        do_new_game("ng1");
        play_round("ko_r1", 15, 3, 0, 0, 1);
        play_round("ko_r2", 15, 3, 0, 0, 1);
        play_round("ko_r3", 4, 1, 0, 0, 1);
        check_eq("ko.a_hp_preset", int'(a_hp), 6);
        play_round("ko_hit", 4, 2, 9, 3, 1);
        check_eq("ko.a_hp_zero",  int'(a_hp), 0);
        check_eq("ko.victory",    int'(victory), 1);
        check_eq("ko.p_hp_const", int'(p_hp), 100);
        @(negedge clk);
        go = 1'b1;
        repeat (3) @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        check_against_model("ko_go_ignored");

        // go held high: exactly one round
        do_new_game("ng2");
        @(negedge clk);
        p_pwr = 4'd3; p_mul = 2'd1; a_pwr = 4'd2; a_mul = 2'd1; p_first = 1'b0;
        go = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_o == 3'd1) cnt++;
        end
        go = 1'b0;
        repeat (2) @(negedge clk);
        model_round(3, 1, 2, 1, 0);
        check_eq("held.rounds", cnt, 1);
        check_against_model("held");

        // second rising edge while busy is dropped
        @(negedge clk);
        p_pwr = 4'd2; p_mul = 2'd2; a_pwr = 4'd1; a_mul = 2'd1; p_first = 1'b1;
        go = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state_o == 3'd1) cnt++;
            go = (i == 1) ? 1'b1 : 1'b0;
        end
        model_round(2, 2, 1, 1, 1);
        check_eq("busy_edge.rounds", cnt, 1);
        check_against_model("busy_edge");

        // new_game in S_LOSS with go high
        do_new_game("ng3");
        play_round("loss_r1", 0, 0, 15, 3, 0);
        play_round("loss_r2", 0, 0, 15, 3, 0);
        play_round("loss_r3", 0, 0, 15, 3, 0);
        check_eq("loss.flag", int'(loss), 1);
        @(negedge clk);
        new_game = 1'b1;
        go = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_reset();
        check_against_model("loss_restart");
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        check_against_model("loss_restart_idle");

        // asynchronous reset in S_APPLY1
        play_round("pre_rst", 5, 2, 3, 1, 1);
        @(negedge clk);
        p_pwr = 4'd5; p_mul = 2'd2; a_pwr = 4'd3; a_mul = 2'd1; p_first = 1'b1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        check_eq("rst_mid.in_apply1", int'(state_o), 2);
        resetn = 1'b0;
        #1;
        model_reset();
        check_against_model("rst_mid_async");
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check_against_model("rst_mid_after");

        // zero multiplier on both sides
        play_round("mul0", 4, 0, 6, 0, 1);
        check_eq("mul0.a_hp_const", int'(a_hp), 100);

        // randomized battles
        for (int r = 0; r < 60; r++) begin
            if (m_over != 0) do_new_game("rnd_ng");
            play_round("rnd", int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
